dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of a single-ported data memory
module dmem_arbiter #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic        a_err,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic        b_err,
    output logic [31:0] b_rdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    logic        sel;          // 0 = port A, 1 = port B
    logic        last_served;  // 0 = port A, 1 = port B
    logic        err_pend;
    logic        rd_pend;

    logic        pick;
    logic        pick_we;
    logic        pick_ok;
    logic [31:0] pick_addr;
    logic [31:0] pick_wdata;

    // Choose the requester for the next access: sole requester, or the port not served last on a tie
    always_comb begin
        pick = 1'b0;
        if (a_req && b_req) begin
            pick = ~last_served;
        end else if (b_req) begin
            pick = 1'b1;
        end
        pick_we    = pick ? b_we    : a_we;
        pick_addr  = pick ? b_addr  : a_addr;
        pick_wdata = pick ? b_wdata : a_wdata;
        pick_ok    = (pick_addr < 32'(DEPTH));
    end

    // Sequencer: IDLE arbitrates, ACCESS drives the memory for one cycle, RESP returns the result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sel         <= 1'b0;
            last_served <= 1'b1;
            err_pend    <= 1'b0;
            rd_pend     <= 1'b0;
            a_gnt       <= 1'b0;
            a_rvalid    <= 1'b0;
            a_err       <= 1'b0;
            a_rdata     <= 32'h0;
            b_gnt       <= 1'b0;
            b_rvalid    <= 1'b0;
            b_err       <= 1'b0;
            b_rdata     <= 32'h0;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        state       <= ACCESS;
                        sel         <= pick;
                        last_served <= pick;
                        a_gnt       <= ~pick;
                        b_gnt       <= pick;
                        // Out-of-range accesses never reach the memory
                        mem_we      <= pick_ok & pick_we;
                        mem_re      <= pick_ok & ~pick_we;
                        mem_addr    <= pick_ok ? pick_addr  : 32'h0;
                        mem_wdata   <= pick_ok ? pick_wdata : 32'h0;
                        err_pend    <= ~pick_ok;
                        rd_pend     <= ~pick_we;
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    a_gnt     <= 1'b0;
                    b_gnt     <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_re    <= 1'b0;
                    mem_addr  <= 32'h0;
                    mem_wdata <= 32'h0;
                    if (!sel) begin
                        a_rvalid <= 1'b1;
                        a_err    <= err_pend;
                        if (rd_pend) begin
                            a_rdata <= err_pend ? 32'h0 : mem_rdata;
                        end
                    end else begin
                        b_rvalid <= 1'b1;
                        b_err    <= err_pend;
                        if (rd_pend) begin
                            b_rdata <= err_pend ? 32'h0 : mem_rdata;
                        end
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    a_rvalid <= 1'b0;
                    a_err    <= 1'b0;
                    b_rvalid <= 1'b0;
                    b_err    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter against a cycle-schedule reference model
module tb_dmem_arbiter;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem_arr [DEPTH];
    logic        preload;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_err(b_err), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural data memory: combinational read, clocked write
    assign mem_rdata = (mem_addr < DEPTH) ? mem_arr[mem_addr[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem_arr[i] <= 32'hA500_0000 | 32'(i);
        end else if (mem_we && mem_addr < DEPTH) begin
            mem_arr[mem_addr[5:0]] <= mem_wdata;
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          free_at = 0;
    logic [31:0] ref_mem [DEPTH];
    bit          last_b;
    logic [31:0] exp_rdata [2];
    bit          t_valid;
    int          t_g;
    bit          t_port;
    bit          t_we;
    logic [31:0] t_addr, t_wdata;
    op_t         qa[$], qb[$];
    bit          act_a, act_b;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Requesters: present the next queued op, hold it until a grant is seen
    task automatic drive();
        op_t op;
        if (act_a && a_gnt) act_a = 0;
        if (act_b && b_gnt) act_b = 0;
        if (!act_a) begin
            if (qa.size() > 0) begin
                op = qa.pop_front();
                a_req = 1'b1; a_we = op.we; a_addr = op.addr; a_wdata = op.wdata; act_a = 1;
            end else begin
                a_req = 1'b0; a_we = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
            end
        end
        if (!act_b) begin
            if (qb.size() > 0) begin
                op = qb.pop_front();
                b_req = 1'b1; b_we = op.we; b_addr = op.addr; b_wdata = op.wdata; act_b = 1;
            end else begin
                b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
            end
        end
    endtask

    // Reference schedule: a request seen while the memory is free is granted at the next
    // edge, responds one cycle later, and the arbiter is free again two cycles after the grant
    task automatic model_edge();
        bit w;
        if (!t_valid && cyc >= free_at && (a_req || b_req)) begin
            if (a_req && b_req) w = last_b ? 1'b0 : 1'b1;
            else if (a_req)     w = 1'b0;
            else                w = 1'b1;
            t_valid = 1; t_g = cyc + 1; t_port = w;
            t_we    = w ? b_we    : a_we;
            t_addr  = w ? b_addr  : a_addr;
            t_wdata = w ? b_wdata : a_wdata;
            last_b  = w;
            free_at = cyc + 3;
        end
    endtask

    task automatic check_outputs();
        bit in_g, in_r, ok;
        in_g = t_valid && cyc == t_g;
        in_r = t_valid && cyc == t_g + 1;
        ok   = t_addr < DEPTH;
        if (in_r && !t_we) exp_rdata[t_port] = ok ? ref_mem[t_addr[5:0]] : 32'h0;
        if (in_r && t_we && ok) ref_mem[t_addr[5:0]] = t_wdata;
        chk1("a_gnt", a_gnt, in_g && !t_port);
        chk1("b_gnt", b_gnt, in_g && t_port);
        chk1("a_rvalid", a_rvalid, in_r && !t_port);
        chk1("b_rvalid", b_rvalid, in_r && t_port);
        chk1("a_err", a_err, in_r && !t_port && !ok);
        chk1("b_err", b_err, in_r && t_port && !ok);
        chk32("a_rdata", a_rdata, exp_rdata[0]);
        chk32("b_rdata", b_rdata, exp_rdata[1]);
        chk1("mem_we", mem_we, in_g && ok && t_we);
        chk1("mem_re", mem_re, in_g && ok && !t_we);
        if (in_g && ok) begin
            chk32("mem_addr", mem_addr, t_addr);
            chk32("mem_wdata", mem_wdata, t_wdata);
        end else if (!in_g) begin
            chk32("mem_addr_idle", mem_addr, 32'h0);
            chk32("mem_wdata_idle", mem_wdata, 32'h0);
        end
        if (in_r) t_valid = 0;
    endtask

    task automatic step();
        drive();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic run(input string tag, input int max);
        int n = 0;
        while ((qa.size() > 0 || qb.size() > 0 || act_a || act_b || t_valid) && n < max) begin
            step();
            n++;
        end
        checks++;
        assert (n < max) else begin
            errors++;
            $error("FAIL %s timeout observed=%0d cycles expected below %0d", tag, n, max);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk1({tag, "_a_gnt"}, a_gnt, 1'b0);
        chk1({tag, "_b_gnt"}, b_gnt, 1'b0);
        chk1({tag, "_a_rvalid"}, a_rvalid, 1'b0);
        chk1({tag, "_b_rvalid"}, b_rvalid, 1'b0);
        chk1({tag, "_a_err"}, a_err, 1'b0);
        chk1({tag, "_b_err"}, b_err, 1'b0);
        chk32({tag, "_a_rdata"}, a_rdata, 32'h0);
        chk32({tag, "_b_rdata"}, b_rdata, 32'h0);
        chk1({tag, "_mem_we"}, mem_we, 1'b0);
        chk1({tag, "_mem_re"}, mem_re, 1'b0);
        chk32({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    task automatic model_reset();
        free_at = cyc; last_b = 1; t_valid = 0; act_a = 0; act_b = 0;
        exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
        qa.delete(); qb.delete();
    endtask

    task automatic apply_reset();
        #1;
        reset = 1'b0;
        a_req = 1'b0; b_req = 1'b0;
        #1;
        check_all_zero("rst_pulse");
        @(posedge clk);
        #1;
        cyc++;
        check_all_zero("rst_hold");
        reset = 1'b1;
        model_reset();
    endtask

    task automatic push_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        op_t op;
        op.we = we; op.addr = addr; op.wdata = wdata;
        qa.push_back(op);
    endtask

    task automatic push_b(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        op_t op;
        op.we = we; op.addr = addr; op.wdata = wdata;
        qb.push_back(op);
    endtask

    initial begin
        int n;
        reset = 1'b0; preload = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
        #2;
        check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        preload = 1'b0;
        check_all_zero("reset_late");
        reset = 1'b1;
        model_reset();

        // Single write then read on port A
        push_a(1'b1, 32'd5, 32'hDEAD_BEEF);
        run("wr5", 20);
        push_a(1'b0, 32'd5, 32'h0);
        run("rd5", 20);
        chk32("rd5_value", a_rdata, 32'hDEAD_BEEF);

        // Simultaneous reads: A wins the tie, B follows three cycles later
        apply_reset();
        push_a(1'b0, 32'd3, 32'h0);
        push_b(1'b0, 32'd7, 32'h0);
        run("tie_after_reset", 20);

        // Continuous contention for six accesses
        for (int i = 0; i < 3; i++) begin
            push_a(1'b0, 32'(10 + i), 32'h0);
            push_b(1'b1, 32'(20 + i), 32'h1000 + 32'(i));
        end
        run("contention", 60);

        // Out-of-range write from B, then an A read of address 0
        push_b(1'b1, 32'd64, 32'h1234_5678);
        run("oor_wr", 20);
        push_a(1'b0, 32'd0, 32'h0);
        run("rd0", 20);
        push_b(1'b0, 32'd100, 32'h0);
        run("oor_rd", 20);

        // Randomised traffic on both ports, including out-of-range addresses
        for (int i = 0; i < 24; i++) begin
            push_a(1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH + 7)), $urandom);
            push_b(1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH + 7)), $urandom);
        end
        run("random_both", 400);
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1) push_a(1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH - 1)), $urandom);
            else push_b(1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH - 1)), $urandom);
            run("random_single", 20);
            step();
        end

        // Reset pulse while an A write to address 9 is in ACCESS
        push_a(1'b1, 32'd9, 32'hCAFE_F00D);
        n = 0;
        while (!(t_valid && cyc == t_g) && n < 10) begin
            step();
            n++;
        end
        chk1("reset_in_access_gnt", a_gnt, 1'b1);
        apply_reset();
        step();
        check_all_zero("post_abort");
        push_a(1'b0, 32'd9, 32'h0);
        push_b(1'b0, 32'd9, 32'h0);
        run("rd9_tie", 20);
        chk32("rd9_value", a_rdata, ref_mem[9]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
